// File: rtl/fifo_fwft_if.sv
// Handshake bundle between fifo_fwft and its producer/consumer.
// master = the stage driving the FIFO, slave = the FIFO itself.
interface fifo_fwft_if #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 16
);
  localparam int CW = $clog2(FIFO_BUFFER_SIZE) + 1;

  logic                       wr_en;
  logic [FIFO_DATA_WIDTH-1:0] din;
  logic                       full;
  logic                       rd_en;
  logic [FIFO_DATA_WIDTH-1:0] dout;
  logic                       empty;
  logic [CW-1:0]              count;
  logic                       overflow;
  logic                       underflow;
  logic [CW-1:0]              hwm;

  modport master (
    output wr_en, din, rd_en,
    input  full, dout, empty, count, overflow, underflow, hwm
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, dout, empty, count, overflow, underflow, hwm
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO; word written at edge N is on dout in cycle N+1.
// Backpressure via full/empty (writes while full and reads while empty are dropped
// and flagged sticky); FIFO_HWM_EN adds a high-water-mark register on hwm.
module fifo_fwft #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 16
) (
  input logic        clock,
  input logic        reset,
  fifo_fwft_if.slave bus
);
  localparam int AW = $clog2(FIFO_BUFFER_SIZE);
  localparam int CW = AW + 1;

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              count_nxt;
  logic                       overflow_q;
  logic                       underflow_q;
  logic                       empty;
  logic                       full;
  logic                       wr_acc;
  logic                       rd_acc;

  // MSB of each pointer is the wrap bit distinguishing full from empty.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_acc)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      count_q <= count_nxt;
      if (bus.wr_en && full)
        overflow_q <= 1'b1;
      if (bus.rd_en && empty)
        underflow_q <= 1'b1;
    end
  end

  // Storage is not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc)
      mem[wr_ptr[AW-1:0]] <= bus.din;
  end

`ifdef FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clock) begin
    if (reset)
      hwm_q <= '0;
    else if (count_nxt > hwm_q)
      hwm_q <= count_nxt;
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

  assign bus.dout      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
- Synchronous first-word-fall-through FIFO that links the streaming DSP stages of the FM radio chain (demod, FIR, IIR, gain, and so on).
- Its read side presents data on dout while empty is low. A consumer takes the word by raising rd_en in the same cycle it uses dout.
- Its write side accepts din when the producer raises wr_en and full is low.
- One clock domain. Memory is a register array.

Parameters:
- FIFO_DATA_WIDTH, 32, width of each stored word.
- FIFO_BUFFER_SIZE, 16, depth in words. Must be a power of two and at least 2.
- CW (localparam), $clog2(FIFO_BUFFER_SIZE)+1, width of the occupancy count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write request from the producer.
- din  in  FIFO_DATA_WIDTH  write data.
- full  out  1  high when occupancy equals FIFO_BUFFER_SIZE.
- rd_en  in  1  read/pop request from the consumer.
- dout  out  FIFO_DATA_WIDTH  head-of-queue word; 0 when empty.
- empty  out  1  high when occupancy is 0.
- count  out  CW  current occupancy, 0..FIFO_BUFFER_SIZE.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.
- hwm  out  CW  high-water mark (see Optional Feature).

Behaviour:
- Reset: one clock, single-clock domain, reset synchronous active-high. On reset, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0, hwm=0. Memory contents are not reset.
- Reset mid-operation: reset wins over any simultaneous wr_en or rd_en. The queue is flushed and no write from that cycle is stored.
- Pointers are log2(depth)+1 bits wide, with the MSB acting as the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
  - Both flags are registered-state derived, with no combinational path from wr_en or rd_en.
- Write accept: wr_en && !full. At the clock edge, mem[wr_ptr] <= din and wr_ptr increments, wrapping modulo 2*depth.
- Read accept: rd_en && !empty. At the clock edge, rd_ptr increments.
- dout = empty ? 0 : mem[rd_ptr[addr]]. This is a combinational read of the array, so it is valid in the same cycle empty is low.
- Latency: a word written at edge N is visible on dout with empty=0 after edge N (usable in cycle N+1). Minimum write-to-read latency is 1 cycle.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted; count unchanged.
  - Empty: only the write is accepted; underflow is set.
  - Full: only the read is accepted; the write is dropped, overflow is set, and count drops by 1. Producers must gate on full.
- count updates at each edge:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both are accepted or neither is.
- Sticky flags: overflow sets on wr_en && full; underflow sets on rd_en && empty. Only reset clears them. Rejected requests do not change pointers or memory.
- Wrap-around: after 2*depth accepted writes and reads, the pointers return to 0 and ordering is preserved.
- No state machine beyond the pointer and count registers. Throughput is one write and one read per cycle sustained.

Optional Feature:
- Macro FIFO_HWM_EN.
- Defined: hwm is a register, reset to 0.
  - Each edge: if the next count exceeds hwm, hwm <= next count.
  - It never decreases except on reset.
  - Used to size buffers in the radio chain.
- Undefined: hwm is tied to 0 and no register is inferred.

Test Plan:
- Reset then idle, depth 16 → empty=1, full=0, count=0, dout=0, overflow=0, underflow=0 for 10 cycles.
- Write 0x11 at edge 1, then hold rd_en=0 → empty=0, dout=0x11, count=1 on the next cycle. Then pulse rd_en → empty=1, dout=0, count=0.
- Write 16 words 0x100..0x10F, then write 0xDEAD while full=1 → full=1, count=16, overflow=1. Then read 16 words → dout sequence is 0x100..0x10F in order, 0xDEAD never appears, empty=1.
- Keep the FIFO half full and drive wr_en=rd_en=1 for 40 cycles with an incrementing din → count stays at 8 with no drop or duplication across pointer wrap. Also: rd_en=1 on an empty FIFO → underflow=1, count stays 0.
- Simultaneous wr_en and rd_en on a full FIFO → read accepted, write dropped, overflow=1, count=15. Simultaneous wr_en and rd_en on an empty FIFO → count=1, dout=din, underflow=1.
- With FIFO_HWM_EN: fill to 12, drain to 3, fill to 7 → hwm=12. Assert reset with 5 words queued → next cycle count=0, empty=1, hwm=0, overflow=0. Without the macro, hwm=0 throughout.
